// File: rtl/fifo_bit_unpacker_if.sv
// Output word stream of the bit unpacker: packed word, valid-bit count and
// a valid/ready handshake.
interface fifo_bit_unpacker_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] m_data;
    logic [CW-1:0]    m_bits;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_bits, output m_valid, input m_ready);
    modport slave  (input m_data, input m_bits, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_bit_unpacker.sv
// Drains a 1-bit FIFO read port, packs the bits into WIDTH-bit words and
// presents them on a valid/ready stream; flush emits a partial word.
//
// state | meaning
// EMPTY | output register free, m_valid=0
// FULL  | word held in output register, m_valid=1
module fifo_bit_unpacker #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter int CW        = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic                 fifo_dout,
    output logic                 fifo_rd,
    input  logic                 flush,
    fifo_bit_unpacker_if.master  m
);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

    typedef enum logic {EMPTY, FULL} out_state_t;

    out_state_t       out_st;
    logic [CW-1:0]    issued;
    logic [CW-1:0]    got;
    logic [CW-1:0]    got_next;
    logic             rd_q;
    logic             flush_pend;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    bits_q;
    logic             out_free;
    logic             flush_req;
    logic             flush_done;
    logic             load_full;
    logic             load_part;
    logic             load;

    // rst gates the strobe so no read is issued while the packer is held in reset
    assign fifo_rd = !rst && !fifo_empty && (issued != FULL_CNT) && !flush_pend;

    always_comb begin
        shift_next = shift_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (rd_q && (got == CW'(LSB_FIRST ? i : WIDTH - 1 - i))) begin
                shift_next[i] = fifo_dout;
            end
        end
    end

    assign got_next   = got + {{(CW-1){1'b0}}, rd_q};
    assign out_free   = (out_st == EMPTY) || m.m_ready;
    assign flush_req  = flush || flush_pend;
    assign flush_done = flush_req && !rd_q && (got == '0);
    assign load_full  = (got_next == FULL_CNT) && out_free;
    assign load_part  = flush_req && !rd_q && (got != '0) && (got != FULL_CNT) && out_free;
    assign load       = load_full || load_part;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_st     <= EMPTY;
            issued     <= '0;
            got        <= '0;
            rd_q       <= 1'b0;
            flush_pend <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            bits_q     <= '0;
        end else begin
            rd_q <= fifo_rd;
            if (load) begin
                out_st     <= FULL;
                data_q     <= shift_next;
                bits_q     <= load_full ? FULL_CNT : got;
                shift_q    <= '0;
                got        <= '0;
                // a strobe issued on the load edge belongs to the next word
                issued     <= {{(CW-1){1'b0}}, fifo_rd};
                flush_pend <= 1'b0;
            end else begin
                if (m.m_ready) begin
                    out_st <= EMPTY;
                end
                shift_q    <= shift_next;
                got        <= got_next;
                issued     <= issued + {{(CW-1){1'b0}}, fifo_rd};
                flush_pend <= flush_req && !flush_done;
            end
        end
    end

    assign m.m_data  = data_q;
    assign m.m_bits  = bits_q;
    assign m.m_valid = (out_st == FULL);
endmodule

// File: tb/tb_fifo_bit_unpacker.sv
// Scoreboarded bench: a 16-deep 1-bit FIFO model feeds two packers (LSB- and
// MSB-first); expected words are built from the pushed bit stream.
module tb_fifo_bit_unpacker;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic m_ready = 1'b1;
    logic fifo_empty;
    logic fifo_dout = 1'b0;
    logic fifo_rd;
    logic fifo_rd_b;

    int vectors = 0;
    int miscompares = 0;

    fifo_bit_unpacker_if #(.WIDTH(W)) s0 ();
    fifo_bit_unpacker_if #(.WIDTH(W)) s1 ();
    assign s0.m_ready = m_ready;
    assign s1.m_ready = m_ready;

    always #5 clk = ~clk;

    fifo_bit_unpacker #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd), .flush(flush), .m(s0)
    );
    fifo_bit_unpacker #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd_b), .flush(flush), .m(s1)
    );

    // FIFO model: write side owned by the driver, read side by this block
    logic fifo_mem [16];
    int   wcnt = 0;
    int   rcnt = 0;
    bit   underflow = 1'b0;
    assign fifo_empty = (wcnt == rcnt);

    always @(posedge clk) begin
        if (fifo_rd || fifo_rd_b) begin
            if (wcnt == rcnt) underflow <= 1'b1;
            else begin
                fifo_dout <= fifo_mem[rcnt % 16];
                rcnt      <= rcnt + 1;
            end
        end
    end

    // Reference model: bits not yet assigned to a word, and expected words
    bit               pend [W];
    int               pend_n = 0;
    logic [W-1:0]     exp_lsb [$];
    logic [W-1:0]     exp_msb [$];
    int               exp_bits [$];

    task automatic close_word();
        int lsb_v = 0;
        int msb_v = 0;
        if (pend_n == 0) return;
        for (int k = 0; k < pend_n; k++) begin
            lsb_v += int'(pend[k]) << k;
            msb_v += int'(pend[k]) << (W - 1 - k);
        end
        exp_lsb.push_back(W'(lsb_v));
        exp_msb.push_back(W'(msb_v));
        exp_bits.push_back(pend_n);
        pend_n = 0;
    endtask

    task automatic push_bit(input bit b);
        fifo_mem[wcnt % 16] = b;
        wcnt++;
        pend[pend_n] = b;
        pend_n++;
        if (pend_n == W) close_word();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every accepted word and checks stability while stalled
    bit           hold_v = 1'b0;
    logic [W-1:0] hold_d = '0;
    always @(negedge clk) begin
        if (rst) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                check("hold_valid", s0.m_valid, 1);
                check("hold_data", s0.m_data, hold_d);
            end
            if (s0.m_valid && m_ready) begin
                if (exp_lsb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %0h, expected no word", s0.m_data);
                end else begin
                    logic [W-1:0] el;
                    logic [W-1:0] em;
                    int eb;
                    el = exp_lsb.pop_front();
                    em = exp_msb.pop_front();
                    eb = exp_bits.pop_front();
                    check("data_lsb", s0.m_data, el);
                    check("bits_lsb", s0.m_bits, eb);
                    check("valid_msb", s1.m_valid, 1);
                    check("data_msb", s1.m_data, em);
                    check("bits_msb", s1.m_bits, eb);
                end
            end
            hold_v = s0.m_valid && !m_ready;
            hold_d = s0.m_data;
        end
    end

    task automatic flush_seq();
        int k = 0;
        m_ready = 1'b1;
        while (wcnt != rcnt && k < 200) begin
            cyc(1);
            k++;
        end
        check("fifo_drained", wcnt - rcnt, 0);
        cyc(2);
        flush = 1'b1;
        close_word();
        cyc(1);
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int first_rd, first_v, nrd, nv, k;
        bit seen;
        bit pat [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        bit fl3 [3] = '{1, 1, 0};

        #1 rst = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_bit(pat[i]);
        cyc(2);
        check("rst_valid", s0.m_valid, 0);
        check("rst_data", s0.m_data, 0);
        check("rst_bits", s0.m_bits, 0);
        check("rst_fifo_rd", fifo_rd, 0);

        // first-word latency
        rst = 1'b0;
        first_rd = -1; first_v = -1; nrd = 0; nv = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (fifo_rd) begin
                nrd++;
                if (first_rd < 0) first_rd = i;
            end
            if (s0.m_valid) begin
                nv++;
                if (first_v < 0) first_v = i;
            end
        end
        check("rd_count", nrd, 8);
        check("valid_latency", first_v - first_rd, 9);
        check("valid_cycles", nv, 1);
        cyc(1);

        // backpressure with two words queued
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_bit(1'($urandom_range(0, 1)));
        nrd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_rd) nrd++;
        end
        check("rd_count16", nrd, 16);
        check("rd_idle", fifo_rd, 0);
        check("held_valid", s0.m_valid, 1);
        cyc(1);
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_valid", s0.m_valid, 1);
        @(negedge clk);
        check("drained_valid", s0.m_valid, 0);
        cyc(1);

        // flush of a 3-bit partial word
        for (int i = 0; i < 3; i++) push_bit(fl3[i]);
        cyc(6);
        check("partial_no_valid", s0.m_valid, 0);
        flush = 1'b1;
        close_word();
        @(negedge clk);
        check("flush_cycle_valid", s0.m_valid, 0);
        cyc(1);
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", s0.m_valid, 1);
        cyc(4);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s0.m_valid) nv++;
        end
        check("empty_flush_valid", nv, 0);
        cyc(1);

        // FIFO runs dry mid-word
        for (int i = 0; i < 5; i++) push_bit(1'($urandom_range(0, 1)));
        cyc(20);
        check("starved_valid", s0.m_valid, 0);
        for (int i = 0; i < 3; i++) push_bit(1'($urandom_range(0, 1)));
        cyc(15);

        // asynchronous reset with a bit in flight
        for (int i = 0; i < 8; i++) push_bit(1'($urandom_range(0, 1)));
        seen = 1'b0;
        k = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            seen = fifo_rd;
            k++;
        end
        check("rd_seen", seen, 1);
        cyc(3);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", s0.m_valid, 0);
        check("arst_data", s0.m_data, 0);
        check("arst_bits", s0.m_bits, 0);
        check("arst_fifo_rd", fifo_rd, 0);
        wcnt = rcnt;
        pend_n = 0;
        exp_lsb.delete();
        exp_msb.delete();
        exp_bits.delete();
        cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) push_bit(1'($urandom_range(0, 1)));
        cyc(15);

        // randomized traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ((wcnt - rcnt) < 16 && $urandom_range(0, 1) == 1)
                push_bit(1'($urandom_range(0, 1)));
            if (i % 97 == 96) flush_seq();
            cyc(1);
        end
        flush_seq();
        cyc(5);
        check("leftover_words", exp_lsb.size(), 0);
        check("underflow", underflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
